// File: rtl/scan_pkg.sv
// Shared types and polarity helpers for the multiplexed digit scanner.
package scan_pkg;

  // Widest select/segment bus the helpers can produce; callers cast down to their width.
  localparam int unsigned MAX_W = 32;
  localparam int unsigned IDX_ARG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_e;

  // All-deasserted select pattern for the given polarity.
  function automatic logic [MAX_W-1:0] sel_off(input logic active_low);
    return {MAX_W{active_low}};
  endfunction

  // All-segments-off pattern for the given polarity.
  function automatic logic [MAX_W-1:0] seg_off(input logic active_low);
    return {MAX_W{active_low}};
  endfunction

  // Single asserted select at position idx, everything else deasserted.
  function automatic logic [MAX_W-1:0] onehot_sel(input logic [IDX_ARG_W-1:0] idx,
                                                   input logic active_low);
    logic [MAX_W-1:0] oh;
    oh = MAX_W'(1) << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell-slot counter: counts 0..DWELL-1 and flags the last blank clock and the last slot clock.
module scan_dwell_timer #(
  parameter int unsigned DWELL = 55,
  parameter int unsigned BLANK = 2,
  parameter int unsigned CNT_W = $clog2(DWELL)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic blank_last_c,
  output logic dwell_last_c
);

  logic [CNT_W-1:0] cnt_q;

  // Full-width terminal compares so a non-power-of-two DWELL never aliases.
  assign blank_last_c = (BLANK != 0) && (cnt_q == CNT_W'(BLANK - 1));
  assign dwell_last_c = (cnt_q == CNT_W'(DWELL - 1));

  // Counter register: cleared on reset/clr, wraps at the end of each slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= dwell_last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed 7-segment scanner: one select per dwell slot, each slot led by an all-off blank gap.
// Optional feature macro: DIGIT_SCAN_DIM_EN adds a Bright[3:0] input gating the select with a 16-step PWM.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned DWELL          = 55,
  parameter int unsigned BLANK          = 2,
  parameter int unsigned SEG_W          = 8,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      En,
`ifdef DIGIT_SCAN_DIM_EN
  input  logic [3:0]                Bright,
`endif
  input  logic [DIGITS-1:0]         Blank_Mask,
  input  logic [DIGITS*SEG_W-1:0]   Digit_Data,
  output logic [DIGITS-1:0]         Column_Scan_Sig,
  output logic [SEG_W-1:0]          Row_Scan_Sig,
  output logic [$clog2(DIGITS)-1:0] Digit_Idx,
  output logic                      Frame_Tick
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = $clog2(DWELL);
  localparam logic [DIGITS-1:0] SEL_OFF  = DIGITS'(sel_off(SEL_ACTIVE_LOW));
  localparam logic [SEG_W-1:0]  SEG_OFF  = SEG_W'(seg_off(SEG_ACTIVE_LOW));
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam scan_state_e       SLOT_START = (BLANK == 0) ? S_DRIVE : S_BLANK;

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] col_q, col_d;
  logic [SEG_W-1:0]  row_q, row_d;
  logic              tick_q, tick_d;
  logic              tmr_clr, tmr_inc;
  logic              blank_last_c, dwell_last_c;
  logic              drive_on;
  logic              dim_ok_c;

  scan_dwell_timer #(
    .DWELL (DWELL),
    .BLANK (BLANK),
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK          (CLK),
    .RST          (RST),
    .clr          (tmr_clr),
    .inc          (tmr_inc),
    .blank_last_c (blank_last_c),
    .dwell_last_c (dwell_last_c)
  );

`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0] pwm_q;

  // Free-running brightness PWM phase, independent of slot timing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign dim_ok_c = (Bright == 4'hF) || (pwm_q < Bright);
`else
  assign dim_ok_c = 1'b1;
`endif

  // Next-state, slot index, frame tick and next output values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    col_d    = SEL_OFF;
    row_d    = SEG_OFF;
    drive_on = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (En) begin
          state_d = SLOT_START;
          idx_d   = '0;
        end
      end
      S_BLANK: begin
        if (!En) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
          if (blank_last_c) begin
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (!En) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
          if (dwell_last_c) begin
            state_d = SLOT_START;
            if (idx_q == LAST_IDX) begin
              idx_d  = '0;
              tick_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        tmr_clr = 1'b1;
      end
    endcase

    // Outputs follow the upcoming state so select and index change on the same edge.
    drive_on = (state_d == S_DRIVE) && !Blank_Mask[idx_d];
    if (drive_on) begin
      row_d = Digit_Data[32'(idx_d) * SEG_W +: SEG_W];
      if (dim_ok_c) begin
        col_d = DIGITS'(onehot_sel(IDX_ARG_W'(idx_d), SEL_ACTIVE_LOW));
      end
    end
  end

  // State, index and output registers; reset overrides enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      col_q   <= SEL_OFF;
      row_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tick_q  <= tick_d;
    end
  end

  assign Column_Scan_Sig = col_q;
  assign Row_Scan_Sig    = row_q;
  assign Digit_Idx       = idx_q;
  assign Frame_Tick      = tick_q;

endmodule
